sdp_wide_write_narrow_read: RTL and testbench
=============================================

Name: sdp_wide_write_narrow_read

Overview:
- Behavioural simple-dual-port RAM with asymmetric ports: a wide write port (4 lanes of DBITS) and a narrow read port (1 lane of DBITS).
- It is the mirror of our narrow-write/wide-read SDP configuration and serves as the gold model for BRAM-inference equivalence checks of that aspect ratio.
- It is also a synthesizable RTL block, so the inference pass can map it onto QLF BRAM primitives.

Parameters:
- ABITS, 10, narrow (read-side) address width; storage depth = 2**ABITS words of DBITS.
- DBITS, 8, narrow word width; the write word is 4*DBITS.
- OREG, 0, 0 = read latency 1 cycle; 1 = extra output register, read latency 2 cycles.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- we  input  1  write enable.
- wa  input  ABITS-2  wide write address.
- wd  input  4*DBITS  write data; lane i = wd[(i+1)*DBITS-1 : i*DBITS].
- wbe  input  4  per-lane write enable; bit i gates lane i.
- re  input  1  read enable.
- ra  input  ABITS  narrow read address.
- rd  output  DBITS  read data.
- rd_valid  output  1  high when rd carries data for an accepted read.

Behaviour:
- Address map: wide write lane i at wa targets narrow word {wa, i[1:0]}, i.e. lane index = low 2 address bits. Read returns narrow word ra.
- Write: on posedge with we=1 and rst=0, each lane i with wbe[i]=1 stores its slice at {wa,i}. Lanes with wbe[i]=0 are unchanged. we=1 with wbe=0 changes nothing.
- Read stage 1: on posedge with re=1, data from word ra is captured into the stage-1 register, and the stage-1 valid flag is set. With re=0, the stage-1 register holds its value and the valid flag clears.
- OREG=0:
  - rd = stage-1 register and rd_valid = stage-1 valid.
  - Latency is 1: ra presented at edge N appears on rd after edge N.
- OREG=1:
  - Stage 2 copies stage 1 every cycle: data only when stage-1 valid = 1; the valid flag is always copied.
  - rd = stage-2 data and rd_valid = stage-2 valid. Latency is 2.
- Read-during-write collision (same edge, ra within the written wide word and its lane enabled): READ_FIRST. rd returns the old content; the new value is visible to the next read.
- Address wrap: full-range addresses are legal; there is no out-of-range condition.
- Memory contents: not initialised and not reset. A read of a never-written word returns X in simulation. The formal miter only compares written words.
- Reset:
  - While rst=1 (asynchronous): rd = 0, rd_valid = 0, all pipeline registers = 0.
  - Writes are suppressed while rst=1. Memory contents written before reset persist.
  - Deassertion is synchronous to the next edge; the first read may be issued on the edge after deassertion.
  - Reset mid-read: the in-flight read is dropped, and rd_valid never pulses for it.
- Back-to-back reads every cycle are supported at full throughput; rd_valid stays high continuously.
- Simultaneous write to word A and read of word B≠A: independent, no interaction.

Test Plan:
1. Write/read all lanes (ABITS=10, DBITS=8, OREG=0):
   - Stimulus: we=1, wbe=4'hF, wa=8'h12, wd=32'hDDCCBBAA; then reads ra=0x048, 0x049, 0x04A, 0x04B on consecutive cycles.
   - Required: rd = AA, BB, CC, DD, each 1 cycle after its ra; rd_valid high for 4 cycles.
2. Lane masking:
   - Stimulus: preload wa=0x12 as in test 1; write wbe=4'b0101, wd=32'h44332211.
   - Required: reads of 0x048..0x04B return 11, BB, 33, DD.
3. Read-during-write collision:
   - Stimulus: word 0x049 holds BB; same edge apply we=1, wbe=4'hF, wa=0x12, wd=32'h0; re=1, ra=0x049.
   - Required: rd=BB. A read the next cycle returns 00.
4. OREG=1 latency:
   - Stimulus: repeat test 1.
   - Required: rd = AA, BB, CC, DD appear 2 cycles after each ra; rd_valid rises exactly 2 cycles after the first re.
5. Reset mid-operation:
   - Stimulus: issue read of 0x048, then assert rst asynchronously between edges before rd updates.
   - Required: rd=0 and rd_valid=0 immediately. A write attempted during rst (wd=32'hFFFFFFFF) is ignored. After release, reading 0x048 returns the prior AA.
6. Wrap and throughput:
   - Stimulus: write wa=0xFF, wd=32'h87654321; continuous reads ra=0x3FC..0x3FF then 0x000.
   - Required: 21, 43, 65, 87, then word 0 contents; rd_valid held high throughout with no gaps.

Source files
------------

// File: rtl/sdp_wide_write_narrow_read.sv
// Simple-dual-port RAM: 4-lane wide write port, single-lane narrow read port.
// Read-first on collisions; optional second output register (OREG).
module sdp_wide_write_narrow_read #(
  parameter int ABITS = 10,
  parameter int DBITS = 8,
  parameter int OREG  = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [ABITS-3:0]   wa,
  input  logic [4*DBITS-1:0] wd,
  input  logic [3:0]         wbe,
  input  logic               re,
  input  logic [ABITS-1:0]   ra,
  output logic [DBITS-1:0]   rd,
  output logic               rd_valid
);

  localparam int DEPTH = 1 << ABITS;

  // Storage is deliberately unreset so it maps onto block RAM.
  logic [DBITS-1:0] mem_q [DEPTH];
  logic [ABITS-1:0] waddr [4];

  logic [DBITS-1:0] rd1_d, rd1_q;
  logic             rv1_d, rv1_q;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      waddr[i] = {wa, 2'(i)};
    end
  end

  always_ff @(posedge clk) begin
    if (we && !rst) begin
      for (int i = 0; i < 4; i++) begin
        if (wbe[i]) begin
          mem_q[waddr[i]] <= wd[i*DBITS +: DBITS];
        end
      end
    end
  end

  // Array read sees pre-edge contents, giving read-first behaviour.
  always_comb begin
    rd1_d = rd1_q;
    rv1_d = re;
    if (re) begin
      rd1_d = mem_q[ra];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd1_q <= '0;
      rv1_q <= 1'b0;
    end else begin
      rd1_q <= rd1_d;
      rv1_q <= rv1_d;
    end
  end

  if (OREG != 0) begin : g_oreg
    logic [DBITS-1:0] rd2_d, rd2_q;
    logic             rv2_d, rv2_q;

    always_comb begin
      rd2_d = rd2_q;
      rv2_d = rv1_q;
      if (rv1_q) begin
        rd2_d = rd1_q;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd2_q <= '0;
        rv2_q <= 1'b0;
      end else begin
        rd2_q <= rd2_d;
        rv2_q <= rv2_d;
      end
    end

    assign rd       = rd2_q;
    assign rd_valid = rv2_q;
  end else begin : g_noreg
    assign rd       = rd1_q;
    assign rd_valid = rv1_q;
  end

endmodule

// File: tb/tb_sdp_wide_write_narrow_read.sv
// Scoreboard bench: both output-register variants driven by shared stimulus,
// expected reads queued from an array model and checked by per-DUT monitors.
module tb_sdp_wide_write_narrow_read;

  typedef struct packed {
    int         due;
    logic [7:0] data;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        we;
  logic [7:0]  wa;
  logic [31:0] wd;
  logic [3:0]  wbe;
  logic        re;
  logic [9:0]  ra;
  logic [7:0]  rd0, rd1;
  logic        rv0, rv1;

  logic [7:0] mem_m [1024];
  exp_t       q0[$];
  exp_t       q1[$];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  sdp_wide_write_narrow_read #(.ABITS(10), .DBITS(8), .OREG(0)) dut0 (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .wbe(wbe),
    .re(re), .ra(ra), .rd(rd0), .rd_valid(rv0)
  );

  sdp_wide_write_narrow_read #(.ABITS(10), .DBITS(8), .OREG(1)) dut1 (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .wbe(wbe),
    .re(re), .ra(ra), .rd(rd1), .rd_valid(rv1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic ok, input logic [31:0] act,
                     input logic [31:0] expv);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // One clock edge of the reference model: reads see old contents, then writes land.
  task automatic step();
    logic        s_we, s_re, s_rst;
    logic [7:0]  s_wa;
    logic [31:0] s_wd;
    logic [3:0]  s_wbe;
    logic [9:0]  s_ra;
    s_we = we; s_re = re; s_rst = rst; s_wa = wa; s_wd = wd; s_wbe = wbe; s_ra = ra;
    @(posedge clk);
    cyc++;
    if (!s_rst && s_re) begin
      q0.push_back('{due: cyc,     data: mem_m[s_ra]});
      q1.push_back('{due: cyc + 1, data: mem_m[s_ra]});
    end
    if (!s_rst && s_we) begin
      for (int i = 0; i < 4; i++) begin
        if (s_wbe[i]) mem_m[{s_wa, 2'(i)}] = s_wd[8*i +: 8];
      end
    end
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    we = 1'b1; wa = a; wd = d; wbe = be; re = 1'b0;
    step();
    we = 1'b0;
  endtask

  task automatic rd_burst(input logic [9:0] a0, input int n);
    for (int i = 0; i < n; i++) begin
      re = 1'b1; ra = a0 + 10'(i);
      step();
    end
    re = 1'b0;
  endtask

  task automatic idle(input int n);
    we = 1'b0; re = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rv0) begin
      chk("oreg0_valid_expected", q0.size() != 0, 32'(rv0), 32'd0);
      if (q0.size() != 0) begin
        e = q0.pop_front();
        chk("oreg0_latency", e.due == cyc, cyc, e.due);
        chk("oreg0_data", rd0 === e.data, 32'(rd0), 32'(e.data));
      end
    end else if (q0.size() != 0 && q0[0].due <= cyc) begin
      e = q0.pop_front();
      chk("oreg0_valid_missing", rv0 === 1'b1, 32'(rv0), 32'd1);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rv1) begin
      chk("oreg1_valid_expected", q1.size() != 0, 32'(rv1), 32'd0);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        chk("oreg1_latency", e.due == cyc, cyc, e.due);
        chk("oreg1_data", rd1 === e.data, 32'(rd1), 32'(e.data));
      end
    end else if (q1.size() != 0 && q1[0].due <= cyc) begin
      e = q1.pop_front();
      chk("oreg1_valid_missing", rv1 === 1'b1, 32'(rv1), 32'd1);
    end
  end

  initial begin
    rst = 1'b1; we = 1'b0; wa = '0; wd = '0; wbe = '0; re = 1'b0; ra = '0;
    #2;
    chk("reset_rd0", rd0 === 8'h00, 32'(rd0), 32'h0);
    chk("reset_rv0", rv0 === 1'b0, 32'(rv0), 32'h0);
    chk("reset_rd1", rd1 === 8'h00, 32'(rd1), 32'h0);
    chk("reset_rv1", rv1 === 1'b0, 32'(rv1), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(1);

    // Fill every word so later random reads are never X.
    for (int a = 0; a < 256; a++) wr(8'(a), $urandom, 4'hF);
    idle(2);

    // All lanes, then four consecutive narrow reads.
    wr(8'h12, 32'hDDCCBBAA, 4'hF);
    rd_burst(10'h048, 4);
    idle(3);

    // Reset asserted between edges while reads are in flight.
    re = 1'b1; ra = 10'h048;
    step();
    re = 1'b0;
    #2 rst = 1'b1;
    q0.delete();
    q1.delete();
    #1;
    chk("midreset_rd0", rd0 === 8'h00, 32'(rd0), 32'h0);
    chk("midreset_rv0", rv0 === 1'b0, 32'(rv0), 32'h0);
    chk("midreset_rd1", rd1 === 8'h00, 32'(rd1), 32'h0);
    chk("midreset_rv1", rv1 === 1'b0, 32'(rv1), 32'h0);
    we = 1'b1; wa = 8'h12; wd = 32'hFFFFFFFF; wbe = 4'hF; re = 1'b1; ra = 10'h048;
    step();
    chk("inreset_rd0", rd0 === 8'h00, 32'(rd0), 32'h0);
    chk("inreset_rd1", rd1 === 8'h00, 32'(rd1), 32'h0);
    we = 1'b0; re = 1'b0; rst = 1'b0;
    idle(1);
    rd_burst(10'h048, 1);
    idle(3);

    // Lane masking over the preloaded word.
    wr(8'h12, 32'h44332211, 4'b0101);
    rd_burst(10'h048, 4);
    idle(2);
    wr(8'h12, 32'hDDCCBBAA, 4'hF);

    // Read-during-write on the same wide word, then read it again.
    we = 1'b1; wa = 8'h12; wd = 32'h0; wbe = 4'hF; re = 1'b1; ra = 10'h049;
    step();
    we = 1'b0;
    step();
    re = 1'b0;
    idle(3);

    // Top-of-range write and reads wrapping to word 0 at full rate.
    wr(8'hFF, 32'h87654321, 4'hF);
    rd_burst(10'h3FC, 5);
    idle(3);

    // Randomised traffic biased toward a few wide words for collisions.
    for (int n = 0; n < 600; n++) begin
      we  = 1'($urandom_range(0, 1));
      wa  = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      wd  = $urandom;
      wbe = 4'($urandom);
      re  = ($urandom_range(0, 3) != 0);
      ra  = ($urandom_range(0, 1) != 0) ? {wa, 2'($urandom)} : 10'($urandom);
      step();
    end
    idle(5);

    chk("oreg0_queue_drained", q0.size() == 0, 32'(q0.size()), 32'h0);
    chk("oreg1_queue_drained", q1.size() == 0, 32'(q1.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
